// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder controller driving one full adder, LSB first.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int               c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_s;
    logic w_c;

    full_adder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        // r_carry still holds the carry into the MSB here
                        sum      <= {w_s, r_acc[WIDTH-1:1]};
                        c_out    <= w_c;
                        overflow <= r_carry ^ w_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= c_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Scoreboard-driven bench for the bit-serial adder controller.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        logic [WIDTH:0] t;
        exp_t r;
        t    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r.s  = t[WIDTH-1:0];
        r.co = t[WIDTH];
        r.ov = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Presents operands with a one-cycle start; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        sb.push_back(model(x, y, ci));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done (bounded); k=1 is the cycle after the accepting edge.
    task automatic wait_done(output int k, output int busy_cnt, output bit seen);
        k        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, c_out, overflow} !== '0)
            begin errors++; $display("FAIL reset_state: got busy=%b done=%b sum=%h co=%b ov=%b, want all 0",
                                     busy, done, sum, c_out, overflow); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int k, bc; bit seen; exp_t e;
        send(8'h5A, 8'h33, 1'b0);
        wait_done(k, bc, seen);
        checks++;
        if (!seen || k !== WIDTH + 1) begin errors++; $display("FAIL basic_latency: got seen=%b cycle=%0d, want cycle %0d", seen, k, WIDTH + 1); end
        checks++;
        if (bc !== WIDTH) begin errors++; $display("FAIL basic_busy: got %0d busy cycles, want %0d", bc, WIDTH); end
        e = sb.pop_front();
        checks++;
        if ({sum, c_out, overflow} !== e) begin errors++; $display("FAIL basic_result: got %h/%b/%b, want %h/%b/%b", sum, c_out, overflow, e.s, e.co, e.ov); end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL basic_hold: got done=%b busy=%b sum=%h, want 0/0/%h", done, busy, sum, e.s); end
        @(posedge clk); #1;
    endtask

    task automatic test_carry;
        int k, bc; bit seen; exp_t e;
        send(8'hFF, 8'h01, 1'b0);
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {sum, c_out, overflow} !== e) begin errors++; $display("FAIL carry_ripple1: got seen=%b %h/%b/%b, want %h/%b/%b", seen, sum, c_out, overflow, e.s, e.co, e.ov); end
        send(8'hFF, 8'h00, 1'b1);
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || k !== WIDTH + 1 || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL carry_ripple2: got seen=%b cycle=%0d %h/%b/%b, want cycle %0d %h/%b/%b", seen, k, sum, c_out, overflow, WIDTH + 1, e.s, e.co, e.ov); end
        @(posedge clk); #1;
    endtask

    task automatic test_neg_overflow;
        int k, bc; bit seen; exp_t e;
        send(8'h80, 8'h80, 1'b0);
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {sum, c_out, overflow} !== e) begin errors++; $display("FAIL neg_overflow: got seen=%b %h/%b/%b, want %h/%b/%b", seen, sum, c_out, overflow, e.s, e.co, e.ov); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int k, bc, extra; bit seen; exp_t e;
        send(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(k, bc, seen);
        e = sb.pop_front();
        // three edges already consumed since the accept, so done lands 3 cycles earlier here
        checks++;
        if (!seen || k !== WIDTH + 1 - 3 || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL ignore_start: got seen=%b cycle=%0d sum=%h, want cycle %0d sum=%h", seen, k, sum, WIDTH + 1 - 3, e.s); end
        extra = 0;
        repeat (15) begin @(negedge clk); if (done || busy) extra++; end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_no_rerun: got %0d active cycles, want 0", extra); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int k, bc; bit seen; exp_t e;
        a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        @(posedge clk);
        #1 a = 8'h03; b = 8'h04;
        sb.push_back(model(8'h03, 8'h04, 1'b0));
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || k !== WIDTH + 1 || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL b2b_first: got seen=%b cycle=%0d sum=%h, want cycle %0d sum=%h", seen, k, sum, WIDTH + 1, e.s); end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== e.s)
            begin errors++; $display("FAIL b2b_reaccept: got busy=%b done=%b sum=%h, want 1/0/%h", busy, done, sum, e.s); end
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || k !== WIDTH || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL b2b_second: got seen=%b cycle=%0d sum=%h, want cycle %0d sum=%h", seen, k + 1, sum, WIDTH + 1, e.s); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int k, bc, extra; bit seen; exp_t e;
        send(8'h55, 8'h22, 1'b0);
        e = sb.pop_back();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, c_out, overflow} !== '0)
            begin errors++; $display("FAIL reset_mid_async: got busy=%b done=%b sum=%h co=%b ov=%b, want all 0", busy, done, sum, c_out, overflow); end
        #3 rst = 1'b0;
        extra = 0;
        repeat (15) begin @(negedge clk); if (done || busy) extra++; end
        checks++;
        if (extra !== 0 || sum !== '0) begin errors++; $display("FAIL reset_mid_abort: got %0d active cycles sum=%h, want 0 and 00", extra, sum); end
        @(posedge clk); #1;
        send(8'h0F, 8'h01, 1'b0);
        wait_done(k, bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || k !== WIDTH + 1 || {sum, c_out, overflow} !== e)
            begin errors++; $display("FAIL reset_mid_restart: got seen=%b cycle=%0d sum=%h, want cycle %0d sum=%h", seen, k, sum, WIDTH + 1, e.s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_neg_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
